// File: rtl/id_ex_issue_pkg.sv
// Shared decode definitions for the ID/EX issue stage: ALU opcodes, RV32I
// opcode/funct encodings and the EX-bound payload bundle.
package id_ex_issue_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned ALU_OP_W   = 5;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned FUNCT3_W   = 3;
  localparam int unsigned OPCODE_W   = 7;
  localparam int unsigned FUNCT7_W   = 7;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_AND   = 5'b00000,
    ALU_OR    = 5'b00001,
    ALU_ADD   = 5'b00010,
    ALU_XOR   = 5'b00011,
    ALU_SLL   = 5'b00100,
    ALU_SRL   = 5'b00101,
    ALU_SUB   = 5'b00110,
    ALU_SRA   = 5'b00111,
    ALU_BEQ   = 5'b01000,
    ALU_BNE   = 5'b01001,
    ALU_BLT   = 5'b01010,
    ALU_BGE   = 5'b01011,
    ALU_BLTU  = 5'b01100,
    ALU_BGEU  = 5'b01101,
    ALU_LUI   = 5'b01110,
    ALU_AUIPC = 5'b01111,
    ALU_LINK  = 5'b10001,
    ALU_SLT   = 5'b11010,
    ALU_SLTU  = 5'b11100
  } alu_op_e;

  // RV32I major opcodes
  localparam logic [OPCODE_W-1:0] OPC_OP     = 7'b0110011;
  localparam logic [OPCODE_W-1:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [OPCODE_W-1:0] OPC_BRANCH = 7'b1100011;
  localparam logic [OPCODE_W-1:0] OPC_LUI    = 7'b0110111;
  localparam logic [OPCODE_W-1:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [OPCODE_W-1:0] OPC_JAL    = 7'b1101111;
  localparam logic [OPCODE_W-1:0] OPC_JALR   = 7'b1100111;
  localparam logic [OPCODE_W-1:0] OPC_LOAD   = 7'b0000011;
  localparam logic [OPCODE_W-1:0] OPC_STORE  = 7'b0100011;

  // ALU-class funct3
  localparam logic [FUNCT3_W-1:0] F3_ADD_SUB = 3'b000;
  localparam logic [FUNCT3_W-1:0] F3_SLL     = 3'b001;
  localparam logic [FUNCT3_W-1:0] F3_SLT     = 3'b010;
  localparam logic [FUNCT3_W-1:0] F3_SLTU    = 3'b011;
  localparam logic [FUNCT3_W-1:0] F3_XOR     = 3'b100;
  localparam logic [FUNCT3_W-1:0] F3_SRL_SRA = 3'b101;
  localparam logic [FUNCT3_W-1:0] F3_OR      = 3'b110;
  localparam logic [FUNCT3_W-1:0] F3_AND     = 3'b111;

  // Branch funct3
  localparam logic [FUNCT3_W-1:0] F3_BEQ  = 3'b000;
  localparam logic [FUNCT3_W-1:0] F3_BNE  = 3'b001;
  localparam logic [FUNCT3_W-1:0] F3_BLT  = 3'b100;
  localparam logic [FUNCT3_W-1:0] F3_BGE  = 3'b101;
  localparam logic [FUNCT3_W-1:0] F3_BLTU = 3'b110;
  localparam logic [FUNCT3_W-1:0] F3_BGEU = 3'b111;

  localparam logic [FUNCT3_W-1:0] F3_JALR = 3'b000;

  localparam logic [FUNCT7_W-1:0] F7_ZERO = 7'b0000000;
  localparam logic [FUNCT7_W-1:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic                  valid;
    alu_op_e               alu_op;
    logic [XLEN-1:0]       a;
    logic [XLEN-1:0]       b;
    logic [XLEN-1:0]       imm;
    logic [XLEN-1:0]       pc;
    logic [REG_ADDR_W-1:0] rd;
    logic [FUNCT3_W-1:0]   funct3;
    logic                  rf_we;
    logic                  mem_re;
    logic                  mem_we;
    logic                  illegal;
  } ex_bundle_t;

  // LB/LH/LW/LBU/LHU
  function automatic logic load_f3_ok(input logic [FUNCT3_W-1:0] f3);
    return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
           (f3 == 3'b100) || (f3 == 3'b101);
  endfunction

  // SB/SH/SW
  function automatic logic store_f3_ok(input logic [FUNCT3_W-1:0] f3);
    return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
  endfunction

endpackage

// File: rtl/imm_gen.sv
// RV32I immediate extraction: all five immediate formats, purely combinational.
module imm_gen
  import id_ex_issue_pkg::*;
(
  input  logic [XLEN-1:0] i_inst,
  output logic [XLEN-1:0] o_imm_i,
  output logic [XLEN-1:0] o_imm_s,
  output logic [XLEN-1:0] o_imm_b,
  output logic [XLEN-1:0] o_imm_u,
  output logic [XLEN-1:0] o_imm_j
);

  // opcode field carries no immediate bits
  logic w_unused_opcode;
  assign w_unused_opcode = ^i_inst[6:0];

  assign o_imm_i = {{20{i_inst[31]}}, i_inst[31:20]};
  assign o_imm_s = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
  assign o_imm_b = {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25],
                    i_inst[11:8], 1'b0};
  assign o_imm_u = {i_inst[31:12], 12'b0};
  assign o_imm_j = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20],
                    i_inst[30:21], 1'b0};

endmodule

// File: rtl/id_ex_issue.sv
// ID/EX issue stage: decodes an RV32I word and registers the EX-bound operands,
// control enables and ALU opcode, with stall hold and branch-redirect flush.
module id_ex_issue
  import id_ex_issue_pkg::*;
(
  input  logic                  cpu_clk,
  input  logic                  cpu_rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [XLEN-1:0]       inst,
  input  logic [XLEN-1:0]       in_pc,
  input  logic [XLEN-1:0]       rs1_data,
  input  logic [XLEN-1:0]       rs2_data,
  input  logic                  stall,
  input  logic                  flush,
  output logic                  ex_valid,
  output logic [ALU_OP_W-1:0]   ex_alu_op,
  output logic [XLEN-1:0]       ex_a,
  output logic [XLEN-1:0]       ex_b,
  output logic [XLEN-1:0]       ex_imm,
  output logic [XLEN-1:0]       ex_pc,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic [FUNCT3_W-1:0]   ex_funct3,
  output logic                  ex_rf_we,
  output logic                  ex_mem_re,
  output logic                  ex_mem_we,
  output logic                  ex_illegal
);

  logic [XLEN-1:0]     w_imm_i;
  logic [XLEN-1:0]     w_imm_s;
  logic [XLEN-1:0]     w_imm_b;
  logic [XLEN-1:0]     w_imm_u;
  logic [XLEN-1:0]     w_imm_j;
  logic [OPCODE_W-1:0] w_opc;
  logic [FUNCT3_W-1:0] w_f3;
  logic [FUNCT7_W-1:0] w_f7;
  logic                w_f7_zero;
  logic                w_f7_alt;
  logic [XLEN-1:0]     w_shamt;
  logic                w_writes;
  logic                w_illegal;
  ex_bundle_t          w_dec;
  ex_bundle_t          r_ex;

  imm_gen u_imm_gen (
    .i_inst  (inst),
    .o_imm_i (w_imm_i),
    .o_imm_s (w_imm_s),
    .o_imm_b (w_imm_b),
    .o_imm_u (w_imm_u),
    .o_imm_j (w_imm_j)
  );

  assign w_opc     = inst[6:0];
  assign w_f3      = inst[14:12];
  assign w_f7      = inst[31:25];
  assign w_f7_zero = (w_f7 == F7_ZERO);
  assign w_f7_alt  = (w_f7 == F7_ALT);
  assign w_shamt   = XLEN'(inst[24:20]);

  assign in_ready = ~stall;

  // Instruction decode into the EX payload
  always_comb begin
    w_dec        = '0;
    w_writes     = 1'b0;
    w_illegal    = 1'b0;
    w_dec.valid  = 1'b1;
    w_dec.alu_op = ALU_AND;
    w_dec.a      = rs1_data;
    w_dec.pc     = in_pc;
    w_dec.rd     = inst[11:7];
    w_dec.funct3 = w_f3;

    case (w_opc)
      OPC_OP: begin
        w_dec.b  = rs2_data;
        w_writes = 1'b1;
        case (w_f3)
          F3_ADD_SUB: w_dec.alu_op = w_f7_alt ? ALU_SUB : ALU_ADD;
          F3_SLL:     w_dec.alu_op = ALU_SLL;
          F3_SLT:     w_dec.alu_op = ALU_SLT;
          F3_SLTU:    w_dec.alu_op = ALU_SLTU;
          F3_XOR:     w_dec.alu_op = ALU_XOR;
          F3_SRL_SRA: w_dec.alu_op = w_f7_alt ? ALU_SRA : ALU_SRL;
          F3_OR:      w_dec.alu_op = ALU_OR;
          default:    w_dec.alu_op = ALU_AND;
        endcase
        // funct7=0100000 only qualifies SUB and SRA
        if (!(w_f7_zero || (w_f7_alt && ((w_f3 == F3_ADD_SUB) || (w_f3 == F3_SRL_SRA)))))
          w_illegal = 1'b1;
      end

      OPC_OP_IMM: begin
        w_dec.b   = w_imm_i;
        w_dec.imm = w_imm_i;
        w_writes  = 1'b1;
        case (w_f3)
          F3_ADD_SUB: w_dec.alu_op = ALU_ADD;
          F3_SLL: begin
            w_dec.alu_op = ALU_SLL;
            w_dec.b      = w_shamt;
            if (!w_f7_zero) w_illegal = 1'b1;
          end
          F3_SLT:  w_dec.alu_op = ALU_SLT;
          F3_SLTU: w_dec.alu_op = ALU_SLTU;
          F3_XOR:  w_dec.alu_op = ALU_XOR;
          F3_SRL_SRA: begin
            w_dec.alu_op = w_f7_alt ? ALU_SRA : ALU_SRL;
            w_dec.b      = w_shamt;
            if (!(w_f7_zero || w_f7_alt)) w_illegal = 1'b1;
          end
          F3_OR:   w_dec.alu_op = ALU_OR;
          default: w_dec.alu_op = ALU_AND;
        endcase
      end

      OPC_BRANCH: begin
        w_dec.b   = rs2_data;
        w_dec.imm = w_imm_b;
        case (w_f3)
          F3_BEQ:  w_dec.alu_op = ALU_BEQ;
          F3_BNE:  w_dec.alu_op = ALU_BNE;
          F3_BLT:  w_dec.alu_op = ALU_BLT;
          F3_BGE:  w_dec.alu_op = ALU_BGE;
          F3_BLTU: w_dec.alu_op = ALU_BLTU;
          F3_BGEU: w_dec.alu_op = ALU_BGEU;
          default: w_illegal    = 1'b1;
        endcase
      end

      OPC_LUI: begin
        w_dec.alu_op = ALU_LUI;
        w_dec.a      = '0;
        w_dec.b      = w_imm_u;
        w_dec.imm    = w_imm_u;
        w_writes     = 1'b1;
      end

      OPC_AUIPC: begin
        w_dec.alu_op = ALU_AUIPC;
        w_dec.a      = in_pc;
        w_dec.b      = w_imm_u;
        w_dec.imm    = w_imm_u;
        w_writes     = 1'b1;
      end

      OPC_JAL: begin
        w_dec.alu_op = ALU_LINK;
        w_dec.a      = '0;
        w_dec.imm    = w_imm_j;
        w_writes     = 1'b1;
      end

      OPC_JALR: begin
        w_dec.alu_op = ALU_LINK;
        w_dec.imm    = w_imm_i;
        w_writes     = 1'b1;
        if (w_f3 != F3_JALR) w_illegal = 1'b1;
      end

      OPC_LOAD: begin
        w_dec.alu_op = ALU_ADD;
        w_dec.b      = w_imm_i;
        w_dec.imm    = w_imm_i;
        w_dec.mem_re = 1'b1;
        w_writes     = 1'b1;
        if (!load_f3_ok(w_f3)) w_illegal = 1'b1;
      end

      OPC_STORE: begin
        w_dec.alu_op = ALU_ADD;
        w_dec.b      = w_imm_s;
        w_dec.imm    = w_imm_s;
        w_dec.mem_we = 1'b1;
        if (!store_f3_ok(w_f3)) w_illegal = 1'b1;
      end

      default: w_illegal = 1'b1;
    endcase

    // An illegal word still travels to EX as valid, but with nothing enabled
    if (w_illegal) begin
      w_dec.alu_op  = ALU_AND;
      w_dec.a       = '0;
      w_dec.b       = '0;
      w_dec.imm     = '0;
      w_dec.mem_re  = 1'b0;
      w_dec.mem_we  = 1'b0;
      w_dec.illegal = 1'b1;
      w_writes      = 1'b0;
    end

    w_dec.rf_we = w_writes && (w_dec.rd != '0);
  end

  // EX pipeline register: flush beats stall beats acceptance
  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      r_ex <= '0;
    end else if (flush) begin
      r_ex.valid   <= 1'b0;
      r_ex.rf_we   <= 1'b0;
      r_ex.mem_re  <= 1'b0;
      r_ex.mem_we  <= 1'b0;
      r_ex.illegal <= 1'b0;
    end else if (!stall) begin
      if (in_valid) begin
        r_ex <= w_dec;
      end else begin
        r_ex.valid   <= 1'b0;
        r_ex.rf_we   <= 1'b0;
        r_ex.mem_re  <= 1'b0;
        r_ex.mem_we  <= 1'b0;
        r_ex.illegal <= 1'b0;
      end
    end
  end

  assign ex_valid   = r_ex.valid;
  assign ex_alu_op  = r_ex.alu_op;
  assign ex_a       = r_ex.a;
  assign ex_b       = r_ex.b;
  assign ex_imm     = r_ex.imm;
  assign ex_pc      = r_ex.pc;
  assign ex_rd      = r_ex.rd;
  assign ex_funct3  = r_ex.funct3;
  assign ex_rf_we   = r_ex.rf_we;
  assign ex_mem_re  = r_ex.mem_re;
  assign ex_mem_we  = r_ex.mem_we;
  assign ex_illegal = r_ex.illegal;

endmodule

// File: tb/tb_id_ex_issue.sv
// Scoreboard bench for id_ex_issue: the driver queues hand-decoded expectations
// on acceptance, the monitor pops and compares whenever EX is loaded.
module tb_id_ex_issue;

  localparam logic [4:0] CA = 5'b00001;  // check ex_a
  localparam logic [4:0] CB = 5'b00010;  // check ex_b
  localparam logic [4:0] CI = 5'b00100;  // check ex_imm
  localparam logic [4:0] CR = 5'b01000;  // check ex_rd
  localparam logic [4:0] CF = 5'b10000;  // check ex_funct3

  typedef struct {
    string       name;
    logic [4:0]  op;
    logic [31:0] a, b, imm, pc;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [3:0]  fl;    // {rf_we, mem_re, mem_we, illegal}
    logic [4:0]  care;
  } exp_t;

  logic        cpu_clk = 1'b0;
  logic        cpu_rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] inst = '0, in_pc = '0, rs1_data = '0, rs2_data = '0;
  logic        stall = 1'b0, flush = 1'b0;
  logic        ex_valid;
  logic [4:0]  ex_alu_op;
  logic [31:0] ex_a, ex_b, ex_imm, ex_pc;
  logic [4:0]  ex_rd;
  logic [2:0]  ex_funct3;
  logic        ex_rf_we, ex_mem_re, ex_mem_we, ex_illegal;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t sbq[$];
  exp_t cur_exp;
  exp_t last_exp;
  logic held_ok = 1'b0;
  logic m_upd = 1'b0, m_stl = 1'b0, m_fl = 1'b0;

  id_ex_issue dut (
    .cpu_clk(cpu_clk), .cpu_rst_n(cpu_rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .inst(inst), .in_pc(in_pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .stall(stall), .flush(flush),
    .ex_valid(ex_valid), .ex_alu_op(ex_alu_op),
    .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm), .ex_pc(ex_pc),
    .ex_rd(ex_rd), .ex_funct3(ex_funct3),
    .ex_rf_we(ex_rf_we), .ex_mem_re(ex_mem_re), .ex_mem_we(ex_mem_we),
    .ex_illegal(ex_illegal)
  );

  always #5 cpu_clk = ~cpu_clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic exp_t mk(input string nm, input logic [4:0] op,
                              input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] imm, input logic [4:0] rd,
                              input logic [2:0] f3, input logic [3:0] fl,
                              input logic [4:0] care);
    exp_t e;
    e.name = nm; e.op = op; e.a = a; e.b = b; e.imm = imm; e.pc = '0;
    e.rd = rd; e.f3 = f3; e.fl = fl; e.care = care;
    return e;
  endfunction

  function automatic logic [31:0] flags();
    return 32'({ex_rf_we, ex_mem_re, ex_mem_we, ex_illegal});
  endfunction

  task automatic cmp_exp(input string pfx, input exp_t e);
    chk({pfx, e.name, ".valid"}, 32'(ex_valid), 32'd1);
    chk({pfx, e.name, ".op"}, 32'(ex_alu_op), 32'(e.op));
    chk({pfx, e.name, ".pc"}, ex_pc, e.pc);
    chk({pfx, e.name, ".flags"}, flags(), 32'(e.fl));
    if (e.care[0]) chk({pfx, e.name, ".a"}, ex_a, e.a);
    if (e.care[1]) chk({pfx, e.name, ".b"}, ex_b, e.b);
    if (e.care[2]) chk({pfx, e.name, ".imm"}, ex_imm, e.imm);
    if (e.care[3]) chk({pfx, e.name, ".rd"}, 32'(ex_rd), 32'(e.rd));
    if (e.care[4]) chk({pfx, e.name, ".f3"}, 32'(ex_funct3), 32'(e.f3));
  endtask

  task automatic check_zero(input string pfx);
    chk({pfx, ".valid"}, 32'(ex_valid), 32'd0);
    chk({pfx, ".op"}, 32'(ex_alu_op), 32'd0);
    chk({pfx, ".a"}, ex_a, 32'd0);
    chk({pfx, ".b"}, ex_b, 32'd0);
    chk({pfx, ".imm"}, ex_imm, 32'd0);
    chk({pfx, ".pc"}, ex_pc, 32'd0);
    chk({pfx, ".rd_f3"}, 32'({ex_rd, ex_funct3}), 32'd0);
    chk({pfx, ".flags"}, flags(), 32'd0);
  endtask

  // Monitor, edge half: note what this edge should do to EX and queue acceptances
  always @(posedge cpu_clk) begin
    if (!cpu_rst_n) begin
      m_upd = 1'b0; m_stl = 1'b0; m_fl = 1'b0; held_ok = 1'b0;
      sbq.delete();
    end else begin
      m_fl  = flush;
      m_stl = stall && !flush;
      m_upd = !stall && !flush;
      if (in_valid && !stall && !flush) sbq.push_back(cur_exp);
    end
  end

  // Monitor, sample half: compare away from the active edge
  always @(negedge cpu_clk) begin
    if (cpu_rst_n) begin
      chk("in_ready", 32'(in_ready), 32'(!stall));
      if (m_fl) begin
        chk("flush.valid", 32'(ex_valid), 32'd0);
        chk("flush.flags", flags(), 32'd0);
        held_ok = 1'b0;
      end else if (m_stl) begin
        if (held_ok) cmp_exp("hold.", last_exp);
        else begin
          chk("hold_bubble.valid", 32'(ex_valid), 32'd0);
          chk("hold_bubble.flags", flags(), 32'd0);
        end
      end else if (m_upd) begin
        if (ex_valid) begin
          if (sbq.size() == 0) begin
            chk("unexpected_valid", 32'(ex_valid), 32'd0);
          end else begin
            last_exp = sbq.pop_front();
            cmp_exp("", last_exp);
            held_ok = 1'b1;
          end
        end else begin
          chk("missing_output", 32'(sbq.size()), 32'd0);
          chk("bubble.flags", flags(), 32'd0);
          held_ok = 1'b0;
        end
      end
      m_fl = 1'b0; m_stl = 1'b0; m_upd = 1'b0;
    end
  end

  task automatic drive(input logic [31:0] i, input logic [31:0] pc,
                       input logic [31:0] r1, input logic [31:0] r2, input exp_t e);
    inst = i; in_pc = pc; rs1_data = r1; rs2_data = r2; in_valid = 1'b1;
    cur_exp = e; cur_exp.pc = pc;
  endtask

  task automatic issue(input logic [31:0] i, input logic [31:0] pc,
                       input logic [31:0] r1, input logic [31:0] r2, input exp_t e);
    drive(i, pc, r1, r2, e);
    @(posedge cpu_clk); #1;
    in_valid = 1'b0;
  endtask

  initial begin
    exp_t e_add, e_sub, e_lui, e_jal, e_slt, e_addi;
    e_add  = mk("add",   5'b00010, 32'd5,  32'd7, 32'd0, 5'd3, 3'd0, 4'b1000, CA|CB|CR|CF);
    e_sub  = mk("sub",   5'b00110, 32'd20, 32'd3, 32'd0, 5'd4, 3'd0, 4'b1000, CA|CB|CR|CF);
    e_lui  = mk("lui",   5'b01110, 32'd0,  32'h12345000, 32'd0, 5'd10, 3'd0, 4'b1000, CB|CR);
    e_jal  = mk("jal",   5'b10001, 32'd0,  32'd0, 32'd16, 5'd1, 3'd0, 4'b1000, CI|CR);
    e_slt  = mk("slt",   5'b11010, 32'd1,  32'd2, 32'd0, 5'd5, 3'd2, 4'b1000, CA|CB|CR|CF);
    e_addi = mk("flushed_addi", 5'b00010, 32'd0, 32'd1, 32'd0, 5'd1, 3'd0, 4'b1000, 5'd0);

    repeat (2) @(posedge cpu_clk);
    #1 check_zero("reset");
    @(negedge cpu_clk);
    cpu_rst_n = 1'b1;

    // Back-to-back decode vectors; the first goes in on the first edge out of reset
    issue(32'h002081B3, 32'h100, 32'd5, 32'd7, e_add);
    issue(32'h40335293, 32'h104, 32'h80000000, 32'd0,
          mk("srai", 5'b00111, 32'h80000000, 32'd3, 32'd0, 5'd5, 3'd5, 4'b1000, CA|CB|CR|CF));
    issue(32'hFE208CE3, 32'h108, 32'd9, 32'd9,
          mk("beq", 5'b01000, 32'd9, 32'd9, 32'hFFFFFFF8, 5'd0, 3'd0, 4'b0000, CA|CB|CI|CF));
    issue(32'hFFFFFFFF, 32'h10C, 32'd1, 32'd2,
          mk("illegal_ones", 5'b00000, 32'd0, 32'd0, 32'd0, 5'd0, 3'd0, 4'b0001, 5'd0));
    issue(32'h00100013, 32'h110, 32'd0, 32'd0,
          mk("addi_x0", 5'b00010, 32'd0, 32'd1, 32'd0, 5'd0, 3'd0, 4'b0000, CA|CB|CR));
    issue(32'h40208233, 32'h114, 32'd20, 32'd3, e_sub);
    issue(32'hFFC12303, 32'h118, 32'h1000, 32'd0,
          mk("lw", 5'b00010, 32'h1000, 32'hFFFFFFFC, 32'd0, 5'd6, 3'd2, 4'b1100, CA|CB|CR|CF));
    issue(32'h0070A423, 32'h11C, 32'h2000, 32'h55,
          mk("sw", 5'b00010, 32'h2000, 32'd8, 32'd0, 5'd0, 3'd2, 4'b0010, CA|CB|CF));
    @(posedge cpu_clk); #1;
    issue(32'h12345537, 32'h120, 32'd0, 32'd0, e_lui);
    issue(32'h010000EF, 32'h124, 32'd0, 32'd0, e_jal);
    issue(32'hFFF1B113, 32'h128, 32'd4, 32'd0,
          mk("sltiu", 5'b11100, 32'd4, 32'hFFFFFFFF, 32'd0, 5'd2, 3'd3, 4'b1000, CA|CB|CR|CF));
    issue(32'h0020A2B3, 32'h12C, 32'd1, 32'd2, e_slt);
    issue(32'h004280E7, 32'h130, 32'h3000, 32'd0,
          mk("jalr", 5'b10001, 32'h3000, 32'd0, 32'd4, 5'd1, 3'd0, 4'b1000, CA|CI|CR));
    issue(32'h022081B3, 32'h134, 32'd1, 32'd2,
          mk("illegal_f7", 5'b00000, 32'd0, 32'd0, 32'd0, 5'd0, 3'd0, 4'b0001, 5'd0));

    // Three stalled cycles hold add while lui waits, then lui goes in
    issue(32'h002081B3, 32'h200, 32'd5, 32'd7, e_add);
    stall = 1'b1;
    drive(32'h12345537, 32'h204, 32'd0, 32'd0, e_lui);
    repeat (3) begin @(posedge cpu_clk); #1; end
    stall = 1'b0;
    @(posedge cpu_clk); #1;
    in_valid = 1'b0;

    // Flush during a stall kills the held instruction
    issue(32'h010000EF, 32'h300, 32'd0, 32'd0, e_jal);
    stall = 1'b1; flush = 1'b1;
    @(posedge cpu_clk); #1;
    stall = 1'b0; flush = 1'b0;
    @(posedge cpu_clk); #1;

    // Flush on the accepting edge wins over acceptance
    drive(32'h00100093, 32'h310, 32'd0, 32'd0, e_addi);
    flush = 1'b1;
    @(posedge cpu_clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(posedge cpu_clk); #1;

    // Asynchronous reset between edges while EX holds a valid instruction
    issue(32'h0020A2B3, 32'h400, 32'd1, 32'd2, e_slt);
    @(negedge cpu_clk); #2;
    chk("pre_reset.valid", 32'(ex_valid), 32'd1);
    cpu_rst_n = 1'b0;
    #1 check_zero("async_reset");
    @(negedge cpu_clk);
    cpu_rst_n = 1'b1;
    @(posedge cpu_clk); #1;

    // Reset in the middle of a stall discards the held instruction
    issue(32'h40208233, 32'h500, 32'd20, 32'd3, e_sub);
    stall = 1'b1;
    @(posedge cpu_clk); #1;
    @(negedge cpu_clk); #2;
    cpu_rst_n = 1'b0;
    #1 check_zero("stall_reset");
    @(negedge cpu_clk);
    cpu_rst_n = 1'b1; stall = 1'b0;
    @(posedge cpu_clk); #1;
    chk("no_replay.valid", 32'(ex_valid), 32'd0);
    @(posedge cpu_clk); #1;
    chk("no_replay2.valid", 32'(ex_valid), 32'd0);

    repeat (2) @(posedge cpu_clk);
    #1 chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/id_ex_issue.md
ID_EX_ISSUE -- requirements
Module: id_ex_issue

Interface
REQ-001 SHALL provide: cpu_clk  in  1  sole clock, all state on rising edge.
REQ-002 SHALL provide: cpu_rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL provide: in_valid  in  1  decode slot holds an instruction; in_ready  out  1  slot accepted this cycle.
REQ-004 SHALL provide: inst  in  32  RV32I word; in_pc  in  32  its PC; rs1_data, rs2_data  in  32 each  register-file read data.
REQ-005 SHALL provide: stall  in  1  EX holds; flush  in  1  kill the EX-bound instruction (branch redirect).
REQ-006 SHALL provide: ex_valid  out  1; ex_alu_op  out  5; ex_a, ex_b, ex_imm, ex_pc  out  32 each; ex_rd  out  5; ex_funct3  out  3.
REQ-007 SHALL provide: ex_rf_we, ex_mem_re, ex_mem_we, ex_illegal  out  1 each.

Function
REQ-008 SHALL decode inst into the 5-bit ALU opcode set: AND 00000, OR 00001, ADD 00010, XOR 00011, SLL 00100, SRL 00101, SUB 00110, SRA 00111, BEQ 01000, BNE 01001, BLT 01010, BGE 01011, BLTU 01100, BGEU 01101, LUI 01110, AUIPC 01111, LINK 10001, SLT 11010, SLTU 11100.
REQ-009 SHALL register all ex_* outputs; latency exactly one cycle from acceptance to ex_valid=1.
REQ-010 SHALL drive in_ready = ~stall (combinational); acceptance = in_valid & in_ready.
REQ-011 SHALL on stall=1 (no flush) hold every ex_* output unchanged.
REQ-012 SHALL on flush=1 clear ex_valid, ex_rf_we, ex_mem_re, ex_mem_we, ex_illegal next edge; flush beats stall and acceptance.
REQ-013 SHALL, when not stalled and nothing accepted, load a bubble (ex_valid=0, all enables 0).
REQ-014 R-type: ex_a=rs1_data, ex_b=rs2_data; SUB/SRA selected by inst[30]; SLT/SLTU by funct3 010/011.
REQ-015 OP-IMM: ex_b=sign-extended I-imm; shifts take shamt inst[24:20], SRAI by inst[30]; SLTI/SLTIU map to SLT/SLTU.
REQ-016 Branch: ex_a=rs1_data, ex_b=rs2_data, ex_imm=sign-extended B-imm (bit0=0), ex_rf_we=0.
REQ-017 LUI/AUIPC: ex_b=U-imm (inst[31:12]<<12); JAL: op LINK, ex_imm=J-imm; JALR: op LINK, ex_a=rs1_data, ex_imm=I-imm.
REQ-018 Load/store: op ADD, ex_a=rs1_data, ex_b=I-imm (load) or S-imm (store); ex_mem_re/ex_mem_we set; ex_funct3=inst[14:12].
REQ-019 SHALL force ex_rf_we=0 when ex_rd=0 or instruction writes no register.
REQ-020 Unknown opcode/funct: ex_illegal=1, ex_alu_op=00000, all enables 0, ex_valid=1.
REQ-021 ex_pc SHALL equal in_pc of the accepted instruction for every class.

Reset
REQ-022 SHALL on cpu_rst_n=0 immediately clear all ex_* outputs to 0 regardless of clock.
REQ-023 SHALL accept the first instruction on the first rising edge with cpu_rst_n=1 and in_valid=1.
REQ-024 Reset asserted mid-stall SHALL discard the held instruction; nothing replays.

Structure
REQ-025 Shared package SHALL hold the ALU opcode constants (REQ-008) and RV32I opcode/funct3 constants, also used by the ALU.
REQ-026 Immediate generation SHALL be a sub-module imm_gen (inst in, I/S/B/U/J immediates out, combinational).

Verification
REQ-027 add x3,x1,x2 (0x002081B3), rs1=5, rs2=7 -> next cycle ex_alu_op=00010, ex_a=5, ex_b=7, ex_rd=3, ex_rf_we=1.
REQ-028 srai x5,x6,3 (0x40335293) -> ex_alu_op=00111, ex_b=3, ex_rd=5.
REQ-029 beq x1,x2,-8 (0xFE208CE3) -> ex_alu_op=01000, ex_imm=0xFFFFFFF8, ex_rf_we=0.
REQ-030 stall=1 three cycles -> in_ready=0, outputs frozen; flush=1 during stall -> ex_valid=0 next edge.
REQ-031 inst 0xFFFFFFFF -> ex_illegal=1, ex_valid=1, enables 0; addi x0,x0,1 -> ex_rf_we=0.
REQ-032 cpu_rst_n pulled low between edges with ex_valid=1 -> ex_valid=0 before next edge.
